// File: rtl/clefia_dp_ctrl_pkg.sv
// Shared types and encodings for the CLEFIA data_processing sequencer.
package clefia_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WK_IN,
    ST_ROUND,
    ST_WK_OUT,
    ST_DONE
  } state_t;

  localparam logic [1:0] MUX1_DATA  = 2'd0;
  localparam logic [1:0] MUX1_WK0   = 2'd1;
  localparam logic [1:0] MUX1_WK1   = 2'd2;
  localparam logic [1:0] MUX1_R11   = 2'd3;

  localparam logic [1:0] MUX3_HOLD  = 2'd0;
  localparam logic [1:0] MUX3_SHIFT = 2'd1;
  localparam logic [1:0] MUX3_ROT   = 2'd2;

  localparam logic [1:0] WK_NONE    = 2'd0;
  localparam logic [1:0] WK_01      = 2'd1;
  localparam logic [1:0] WK_23      = 2'd2;

  localparam logic [4:0] ROUNDS_128 = 5'd18;
  localparam logic [4:0] ROUNDS_192 = 5'd22;
  localparam logic [4:0] ROUNDS_256 = 5'd26;

  function automatic logic [4:0] rounds_of(input logic [1:0] key_len);
    case (key_len)
      2'd0:    return ROUNDS_128;
      2'd1:    return ROUNDS_192;
      default: return ROUNDS_256;
    endcase
  endfunction

  // Decryption walks the round keys from the last round back to the first.
  function automatic logic [5:0] rk_index(input logic [4:0] r, input logic half,
                                          input logic dec, input logic [4:0] rounds);
    logic [4:0] rr;
    rr = dec ? (rounds - 5'd1 - r) : r;
    return {rr, half};
  endfunction

endpackage

// File: rtl/clefia_dp_ctrl_if.sv
// Control bundle between the sequencer (master) and the top-level FSM / datapath (slave).
interface clefia_dp_ctrl_if #(parameter int RK_IDX_W = 6);
  logic                start;
  logic [1:0]          key_len;
  logic                dec;
  logic                rk_valid;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [1:0]          wk_sel;
  logic [1:0]          sel_mux_1;
  logic                sel_mux_2;
  logic [1:0]          sel_mux_3;
  logic [2:0]          sel_mux_4;
  logic                sel_mux_5;
  logic                selecao_f0_f1;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, key_len, dec, rk_valid,
    output rk_idx, wk_sel, sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_4, sel_mux_5,
           selecao_f0_f1, busy, done, err
  );

  modport slave (
    output start, key_len, dec, rk_valid,
    input  rk_idx, wk_sel, sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_4, sel_mux_5,
           selecao_f0_f1, busy, done, err
  );
endinterface

// File: rtl/clefia_dp_ctrl_round_cnt.sv
// Phase/round counters with round-key stall; exports next-cycle counts and a registered rk_idx.
module clefia_ctrl_round_cnt
  import clefia_ctrl_pkg::*;
#(
  parameter int F_LAT    = 2,
  parameter int RK_IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  state_t              i_state,
  input  logic                i_rk_valid,
  input  logic                i_dec,
  input  logic [4:0]          i_rounds,
  output logic [2:0]          o_phase_nxt,
  output logic [4:0]          o_round_nxt,
  output logic                o_last_phase,
  output logic                o_last_round,
  output logic                o_stall,
  output logic [RK_IDX_W-1:0] o_rk_idx
);

  localparam logic [2:0] PH_HALF = 3'(F_LAT + 2);
  localparam logic [2:0] PH_LAST = 3'(2 * (F_LAT + 2) - 1);
  localparam logic [2:0] PH_XOR  = 3'(F_LAT + 1);

  logic [2:0]          r_phase;
  logic [4:0]          r_round;
  logic [RK_IDX_W-1:0] r_rk_idx;
  logic [2:0]          w_term;
  logic [4:0]          w_round_last;
  logic [RK_IDX_W-1:0] w_rk_nxt;

  assign w_round_last = i_rounds - 5'd1;
  assign o_stall      = (i_state == ST_ROUND) && ((r_phase == 3'd0) || (r_phase == PH_HALF))
                        && !i_rk_valid;
  assign o_last_phase = (r_phase == w_term) && !o_stall;
  assign o_last_round = (r_round == w_round_last);
  assign o_rk_idx     = r_rk_idx;

  always_comb begin
    w_term = 3'd0;
    case (i_state)
      ST_LOAD:            w_term = 3'd3;
      ST_WK_IN, ST_WK_OUT: w_term = 3'd1;
      ST_ROUND:           w_term = PH_LAST;
      default:            w_term = 3'd0;
    endcase
  end

  always_comb begin
    o_phase_nxt = r_phase + 3'd1;
    o_round_nxt = r_round;
    if ((i_state == ST_IDLE) || (i_state == ST_DONE)) o_phase_nxt = 3'd0;
    else if (o_stall)                                 o_phase_nxt = r_phase;
    else if (o_last_phase)                            o_phase_nxt = 3'd0;
    if (i_state != ST_ROUND)  o_round_nxt = 5'd0;
    else if (o_last_phase)    o_round_nxt = o_last_round ? 5'd0 : r_round + 5'd1;
  end

  // The key for each F issue is put out one cycle early, so look at the next phase.
  always_comb begin
    w_rk_nxt = '0;
    if ((i_state == ST_WK_IN) && o_last_phase)
      w_rk_nxt = RK_IDX_W'(rk_index(5'd0, 1'b0, i_dec, i_rounds));
    else if ((i_state == ST_ROUND) && !(o_last_phase && o_last_round)) begin
      if ((o_phase_nxt == PH_LAST) && (o_round_nxt != w_round_last))
        w_rk_nxt = RK_IDX_W'(rk_index(o_round_nxt + 5'd1, 1'b0, i_dec, i_rounds));
      else if (o_phase_nxt >= PH_XOR)
        w_rk_nxt = RK_IDX_W'(rk_index(o_round_nxt, 1'b1, i_dec, i_rounds));
      else
        w_rk_nxt = RK_IDX_W'(rk_index(o_round_nxt, 1'b0, i_dec, i_rounds));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= 3'd0;
      r_round  <= 5'd0;
      r_rk_idx <= '0;
    end else begin
      r_phase  <= o_phase_nxt;
      r_round  <= o_round_nxt;
      r_rk_idx <= w_rk_nxt;
    end
  end

endmodule

// File: rtl/clefia_dp_ctrl.sv
// CLEFIA data_processing sequencer: state FSM with select outputs registered from the next state.
module clefia_dp_ctrl
  import clefia_ctrl_pkg::*;
#(
  parameter int RK_IDX_W = 6,
  parameter int F_LAT    = 2
) (
  input logic               clk,
  input logic               rst_n,
  clefia_dp_ctrl_if.master  io_bus
);

  localparam logic [2:0] PH_HALF = 3'(F_LAT + 2);
  localparam logic [2:0] PH_XOR  = 3'(F_LAT + 1);

  state_t     r_state, w_state_nxt;
  logic [4:0] r_rounds;
  logic       r_dec;
  logic [2:0] w_phase_nxt, w_hp;
  logic [4:0] w_round_nxt;
  logic       w_last_phase, w_last_round, w_stall, w_half;
  logic       w_accept, w_kl_bad;

  logic [1:0] r_wk_sel, w_wk_sel;
  logic [1:0] r_mux_1, w_mux_1;
  logic       r_mux_2, w_mux_2;
  logic [1:0] r_mux_3, w_mux_3;
  logic [2:0] r_mux_4, w_mux_4;
  logic       r_mux_5, w_mux_5;
  logic       r_sel_f, w_sel_f;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_err, w_err;

  assign w_kl_bad = (io_bus.key_len == 2'd3);
  assign w_accept = (r_state == ST_IDLE) && io_bus.start && !w_kl_bad;
  assign w_err    = (r_state == ST_IDLE) && io_bus.start && w_kl_bad;

  clefia_ctrl_round_cnt #(.F_LAT(F_LAT), .RK_IDX_W(RK_IDX_W)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_state      (r_state),
    .i_rk_valid   (io_bus.rk_valid),
    .i_dec        (r_dec),
    .i_rounds     (r_rounds),
    .o_phase_nxt  (w_phase_nxt),
    .o_round_nxt  (w_round_nxt),
    .o_last_phase (w_last_phase),
    .o_last_round (w_last_round),
    .o_stall      (w_stall),
    .o_rk_idx     (io_bus.rk_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)                     w_state_nxt = ST_LOAD;
      ST_LOAD:   if (w_last_phase)                 w_state_nxt = ST_WK_IN;
      ST_WK_IN:  if (w_last_phase)                 w_state_nxt = ST_ROUND;
      ST_ROUND:  if (w_last_phase && w_last_round) w_state_nxt = ST_WK_OUT;
      ST_WK_OUT: if (w_last_phase)                 w_state_nxt = ST_DONE;
      ST_DONE:                                     w_state_nxt = ST_IDLE;
      default:                                     w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_half = (w_phase_nxt >= PH_HALF);
  assign w_hp   = w_half ? (w_phase_nxt - PH_HALF) : w_phase_nxt;

  always_comb begin
    w_wk_sel = WK_NONE;
    w_mux_1  = MUX1_DATA;
    w_mux_2  = 1'b0;
    w_mux_3  = MUX3_HOLD;
    w_mux_4  = 3'd0;
    w_mux_5  = 1'b0;
    w_sel_f  = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (w_state_nxt)
      ST_LOAD: begin
        w_busy  = 1'b1;
        w_mux_3 = MUX3_SHIFT;
        w_mux_4 = {1'b0, w_phase_nxt[1:0]};
      end
      ST_WK_IN, ST_WK_OUT: begin
        w_busy   = 1'b1;
        w_wk_sel = ((w_state_nxt == ST_WK_IN) ^ r_dec) ? WK_01 : WK_23;
        w_mux_3  = MUX3_SHIFT;
        w_mux_1  = w_phase_nxt[0] ? MUX1_WK1 : MUX1_WK0;
        w_mux_4  = w_phase_nxt[0] ? 3'd3 : 3'd1;
      end
      ST_ROUND: begin
        w_busy  = 1'b1;
        w_sel_f = w_half;
        if (w_hp == 3'd0)
          w_mux_2 = w_stall;
        else if (w_hp == PH_XOR) begin
          w_mux_5 = 1'b1;
          if (w_half)
            w_mux_3 = (w_round_nxt == r_rounds - 5'd1) ? MUX3_HOLD : MUX3_ROT;
        end else
          w_mux_2 = 1'b1;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rounds <= 5'd0;
      r_dec    <= 1'b0;
      r_wk_sel <= WK_NONE;
      r_mux_1  <= MUX1_DATA;
      r_mux_2  <= 1'b0;
      r_mux_3  <= MUX3_HOLD;
      r_mux_4  <= 3'd0;
      r_mux_5  <= 1'b0;
      r_sel_f  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      if (w_accept) begin
        r_rounds <= rounds_of(io_bus.key_len);
        r_dec    <= io_bus.dec;
      end
      r_wk_sel <= w_wk_sel;
      r_mux_1  <= w_mux_1;
      r_mux_2  <= w_mux_2;
      r_mux_3  <= w_mux_3;
      r_mux_4  <= w_mux_4;
      r_mux_5  <= w_mux_5;
      r_sel_f  <= w_sel_f;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  assign io_bus.wk_sel        = r_wk_sel;
  assign io_bus.sel_mux_1     = r_mux_1;
  assign io_bus.sel_mux_2     = r_mux_2;
  assign io_bus.sel_mux_3     = r_mux_3;
  assign io_bus.sel_mux_4     = r_mux_4;
  assign io_bus.sel_mux_5     = r_mux_5;
  assign io_bus.selecao_f0_f1 = r_sel_f;
  assign io_bus.busy          = r_busy;
  assign io_bus.done          = r_done;
  assign io_bus.err           = r_err;

endmodule

// File: tb/tb_clefia_dp_ctrl.sv
// Directed bench for clefia_dp_ctrl: vector table of whole operations plus hand-written corner sequences.
module tb_clefia_dp_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clefia_dp_ctrl_if #(.RK_IDX_W(6)) bus ();

  clefia_dp_ctrl #(.RK_IDX_W(6), .F_LAT(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] kl;
    logic       dec;
    int         stall_len;
    int         start_mid;
    int         lat;
    int         rot;
    int         wk_in;
    int         wk_out;
    int         rk_first;
    int         rk_last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rounds_for(input logic [1:0] kl);
    return 18 + 4 * int'(kl);
  endfunction

  function automatic int exp_rk(input int k, input int r_total, input logic dec);
    return dec ? (2 * (r_total - 1 - k / 2) + k % 2) : k;
  endfunction

  function automatic int all_outs();
    return int'({bus.wk_sel, bus.sel_mux_1, bus.sel_mux_2, bus.sel_mux_3, bus.sel_mux_4,
                 bus.sel_mux_5, bus.selecao_f0_f1, bus.busy, bus.done, bus.err, bus.rk_idx});
  endfunction

  function automatic logic is_issue();
    return bus.busy && !bus.done && (bus.wk_sel == 2'd0) && (bus.sel_mux_3 == 2'd0)
           && !bus.sel_mux_2 && !bus.sel_mux_5;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    int r_total, n, rot, wk_in, wk_out, nrk, rk_bad, rk_first, rk_last, rk_max, bad, held;
    v = vecs[i];
    r_total = rounds_for(v.kl);
    rot = 0; wk_in = 0; wk_out = 0; nrk = 0; rk_bad = 0;
    rk_first = -1; rk_last = -1; rk_max = 0; bad = 0; held = 0;
    bus.key_len = v.kl;
    bus.dec     = v.dec;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 400) begin
      if (!bus.busy || bus.err) bad++;
      if (bus.sel_mux_3 == 2'd2) rot++;
      if (bus.wk_sel != 2'd0) begin
        if (wk_in == 0) wk_in = int'(bus.wk_sel);
        wk_out = int'(bus.wk_sel);
      end
      if (int'(bus.rk_idx) > rk_max) rk_max = int'(bus.rk_idx);
      if (held > 0) begin
        if (!(bus.selecao_f0_f1 && bus.sel_mux_2 && !bus.sel_mux_5
              && int'(bus.rk_idx) == exp_rk(1, r_total, v.dec))) bad++;
        held--;
        if (held == 0) bus.rk_valid = 1'b1;
      end else if (is_issue()) begin
        if (nrk == 0) rk_first = int'(bus.rk_idx);
        rk_last = int'(bus.rk_idx);
        if (int'(bus.rk_idx) != exp_rk(nrk, r_total, v.dec)) rk_bad++;
        nrk++;
        if (v.stall_len > 0 && nrk == 2) begin
          bus.rk_valid = 1'b0;
          held = v.stall_len;
        end
      end
      bus.start = (n == v.start_mid);
      tick();
      n++;
    end
    bus.start    = 1'b0;
    bus.rk_valid = 1'b1;
    chk($sformatf("v%0d latency", i), n, v.lat);
    chk($sformatf("v%0d busy_err_held", i), bad, 0);
    chk($sformatf("v%0d rotates", i), rot, v.rot);
    chk($sformatf("v%0d wk_in", i), wk_in, v.wk_in);
    chk($sformatf("v%0d wk_out", i), wk_out, v.wk_out);
    chk($sformatf("v%0d rk_count", i), nrk, 2 * r_total);
    chk($sformatf("v%0d rk_seq_errs", i), rk_bad, 0);
    chk($sformatf("v%0d rk_first", i), rk_first, v.rk_first);
    chk($sformatf("v%0d rk_last", i), rk_last, v.rk_last);
    chk($sformatf("v%0d rk_max", i), rk_max, 2 * r_total - 1);
    chk($sformatf("v%0d done_busy_at_done", i), int'({bus.done, bus.busy}), 3);
    tick();
    chk($sformatf("v%0d after_done", i), int'({bus.done, bus.busy}), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.key_len  = 2'd0;
    bus.dec      = 1'b0;
    bus.rk_valid = 1'b1;

    vecs[0] = '{2'd0, 1'b0, 0, -1, 152, 17, 1, 2, 0, 35};
    vecs[1] = '{2'd1, 1'b0, 0, 50, 184, 21, 1, 2, 0, 43};
    vecs[2] = '{2'd2, 1'b1, 0, -1, 216, 25, 2, 1, 50, 1};
    vecs[3] = '{2'd0, 1'b0, 3, -1, 155, 17, 1, 2, 0, 35};
    vecs[4] = '{2'd1, 1'b1, 0, -1, 184, 21, 2, 1, 42, 1};

    #12;
    chk("reset_outputs", all_outs(), 0);
    #10 rst_n = 1'b1;
    tick();

    // Reserved key length: error pulse, request dropped.
    bus.key_len = 2'd3;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("err_pulse", int'({bus.err, bus.busy}), 2);
    tick();
    chk("err_cleared", int'({bus.err, bus.busy}), 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Async reset in round 5, phase 3.
    bus.key_len = 2'd0;
    bus.dec     = 1'b0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (n < 49) begin
      tick();
      n++;
    end
    chk("r5p3_selects", int'({bus.sel_mux_5, bus.selecao_f0_f1, bus.busy}), 5);
    chk("r5p3_rk_idx", int'(bus.rk_idx), 11);
    rst_n = 1'b0;
    #2;
    chk("mid_reset_outputs", all_outs(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", int'(bus.busy), 0);
    run_vec(0);

    // Back-to-back: start held high through DONE.
    bus.key_len = 2'd0;
    bus.dec     = 1'b0;
    bus.start   = 1'b1;
    tick();
    n = 0;
    while (!bus.done && n < 400) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", n, 152);
    tick();
    chk("b2b_busy_gap", int'({bus.busy, bus.done}), 0);
    tick();
    bus.start = 1'b0;
    chk("b2b_reaccept", int'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 400) begin
      tick();
      n++;
    end
    chk("b2b_second_latency", n, 152);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
